// File: rtl/rvlab_tlul_arb_pkg.sv
// -----------------------------------------------------------------------------
// rvlab_tlul_arb_pkg
// Shared definitions for the two-host TL-UL arbiter: host index type, host
// count, arbiter FSM states and the grant selection helper.
// -----------------------------------------------------------------------------
package rvlab_tlul_arb_pkg;

  localparam int unsigned NumHosts = 2;

  typedef logic [$clog2(NumHosts)-1:0] host_idx_t;

  localparam host_idx_t HostCore = 1'b0;  // core data port
  localparam host_idx_t HostDbg  = 1'b1;  // debug system-bus access port

  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  // Winner among the requesting hosts. On contention the debug host wins
  // outright when dbg_prio is set, otherwise the host not granted last wins.
  function automatic host_idx_t arb_pick(input logic      req0,
                                         input logic      req1,
                                         input host_idx_t last,
                                         input logic      dbg_prio);
    if (req0 && req1) begin
      return dbg_prio ? HostDbg : ~last;
    end else if (req1) begin
      return HostDbg;
    end
    return HostCore;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TileLink-UL type package: A/D opcodes and the host-to-device /
// device-to-host channel bundles shared by every TL-UL block in the lab.
// -----------------------------------------------------------------------------
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/rvlab_tlul_host_arb_if.sv
// -----------------------------------------------------------------------------
// rvlab_tlul_host_arb_if
// One TL-UL link (request bundle h2d, response bundle d2h).
//   modport host   : drives h2d, receives d2h (a bus master)
//   modport device : receives h2d, drives d2h (a bus slave)
// -----------------------------------------------------------------------------
interface rvlab_tlul_host_arb_if;

  tlul_pkg::tl_h2d_t h2d;
  tlul_pkg::tl_d2h_t d2h;

  modport host   (output h2d, input  d2h);
  modport device (input  h2d, output d2h);

endinterface

// File: rtl/rvlab_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// rvlab_arb_id_fifo
// Records which host owns each accepted-but-unanswered A request so that the
// in-order D responses can be routed back. No flow-through: a word written
// this cycle is visible at the head only from the next cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wvalid_i      : push wdata_i (ignored when full)
//   wdata_i       : host index of the accepted request
//   rready_i      : pop the head entry (ignored when empty)
//   rvalid_o      : FIFO not empty
//   rdata_o       : host index at the head
//   count_o       : number of stored entries
// -----------------------------------------------------------------------------
module rvlab_arb_id_fifo
  import rvlab_tlul_arb_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wvalid_i,
  input  host_idx_t       wdata_i,
  input  logic            rready_i,
  output logic            rvalid_o,
  output host_idx_t       rdata_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  host_idx_t       mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign rvalid_o = (cnt_q != '0);
  assign rdata_o  = mem_q[rptr_q];
  assign count_o  = cnt_q;
  assign push     = wvalid_i && (cnt_q != CntW'(Depth));
  assign pop      = rready_i && rvalid_o;

  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/rvlab_tlul_host_arb.sv
// -----------------------------------------------------------------------------
// rvlab_tlul_host_arb
// Two-host to one-device TL-UL arbiter. Host 0 is the core data port, host 1
// the debug SBA port. A-channel grant is combinational (zero latency), held
// once offered until the device accepts; accepted requests are tagged in an
// ID FIFO so that in-order D responses are steered to their owner.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   tl_h0_h2d_i / tl_h0_d2h_o : host 0 request / response
//   tl_h1_h2d_i / tl_h1_d2h_o : host 1 request / response
//   tl_d_h2d_o  / tl_d_d2h_i  : shared device request / response
//   idle_o                    : no held grant and nothing outstanding
// Parameters: MaxOutstanding (1..8) caps unanswered requests; DbgPrio=1 gives
// host 1 fixed priority, 0 selects round-robin.
// -----------------------------------------------------------------------------
module rvlab_tlul_host_arb
  import rvlab_tlul_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          DbgPrio        = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_h0_h2d_i,
  output tlul_pkg::tl_d2h_t tl_h0_d2h_o,
  input  tlul_pkg::tl_h2d_t tl_h1_h2d_i,
  output tlul_pkg::tl_d2h_t tl_h1_d2h_o,
  output tlul_pkg::tl_h2d_t tl_d_h2d_o,
  input  tlul_pkg::tl_d2h_t tl_d_d2h_i,
  output logic              idle_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  arb_state_e      state_q, state_d;
  host_idx_t       gnt_q, gnt_d;
  host_idx_t       last_q, last_d;
  host_idx_t       gnt_sel;
  host_idx_t       head_host;
  logic            gnt_vld;
  logic            sel_a_valid;
  logic            a_hs;
  logic            slot_free;
  logic            fifo_rvalid;
  logic            head_d_ready;
  logic            d_pop;
  logic [CntW-1:0] fifo_cnt;

  // Registered count only: a response popping this cycle frees its slot for
  // the next cycle, keeping the device a_valid free of a D->A comb path.
  // Gating with rst_ni silences every valid/ready output while in reset.
  assign slot_free = rst_ni && (fifo_cnt < CntW'(MaxOutstanding));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      gnt_q   <= HostCore;
      last_q  <= HostDbg;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic, including the grant decision
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    gnt_vld     = 1'b0;
    gnt_sel     = gnt_q;
    if (slot_free) begin
      if (state_q == ArbLocked) begin
        gnt_vld = 1'b1;
      end else if (tl_h0_h2d_i.a_valid || tl_h1_h2d_i.a_valid) begin
        gnt_vld = 1'b1;
        gnt_sel = arb_pick(tl_h0_h2d_i.a_valid, tl_h1_h2d_i.a_valid, last_q, DbgPrio);
      end
    end
    sel_a_valid = (gnt_sel == HostDbg) ? tl_h1_h2d_i.a_valid : tl_h0_h2d_i.a_valid;
    a_hs        = gnt_vld && sel_a_valid && tl_d_d2h_i.a_ready;
    case (state_q)
      ArbIdle: begin
        // A stalled offer freezes the grant so the other host cannot steal it.
        if (gnt_vld && sel_a_valid && !tl_d_d2h_i.a_ready) begin
          state_d = ArbLocked;
          gnt_d   = gnt_sel;
        end
      end
      ArbLocked: begin
        if (a_hs) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
    if (a_hs) begin
      last_d = gnt_sel;
    end
  end

  assign head_d_ready = (head_host == HostDbg) ? tl_h1_h2d_i.d_ready : tl_h0_h2d_i.d_ready;
  assign d_pop        = fifo_rvalid && head_d_ready && tl_d_d2h_i.d_valid;

  rvlab_arb_id_fifo #(
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wvalid_i (a_hs),
    .wdata_i  (gnt_sel),
    .rready_i (d_pop),
    .rvalid_o (fifo_rvalid),
    .rdata_o  (head_host),
    .count_o  (fifo_cnt)
  );

  // Output logic
  always_comb begin
    tl_d_h2d_o = '0;
    if (gnt_vld) begin
      tl_d_h2d_o = (gnt_sel == HostDbg) ? tl_h1_h2d_i : tl_h0_h2d_i;
    end
    tl_d_h2d_o.d_ready = fifo_rvalid && head_d_ready;

    tl_h0_d2h_o         = tl_d_d2h_i;
    tl_h0_d2h_o.a_ready = gnt_vld && (gnt_sel == HostCore) && tl_d_d2h_i.a_ready;
    tl_h0_d2h_o.d_valid = fifo_rvalid && (head_host == HostCore) && tl_d_d2h_i.d_valid;

    tl_h1_d2h_o         = tl_d_d2h_i;
    tl_h1_d2h_o.a_ready = gnt_vld && (gnt_sel == HostDbg) && tl_d_d2h_i.a_ready;
    tl_h1_d2h_o.d_valid = fifo_rvalid && (head_host == HostDbg) && tl_d_d2h_i.d_valid;
  end

  // Registered-state idle: an offered but unaccepted request only counts as
  // pending once it has locked the grant.
  assign idle_o = (state_q == ArbIdle) && (fifo_cnt == '0);

endmodule

// File: tb/tb_rvlab_tlul_host_arb.sv
// -----------------------------------------------------------------------------
// tb_rvlab_tlul_host_arb
// Directed bench for the two-host TL-UL arbiter. u_rr uses the default
// round-robin build; u_prio (DbgPrio=1) sees the same stimulus.
// -----------------------------------------------------------------------------
module tb_rvlab_tlul_host_arb;
  import tlul_pkg::*;

  localparam logic [31:0] DevData = 32'hCAFE_0123;

  // inputs  {h0_av, h1_av, dev_a_ready, dev_d_valid, h0_d_ready, h1_d_ready}
  // outputs {dev_av, h0_ar, h1_ar, h0_dv, h1_dv, dev_d_ready, idle}
  typedef struct packed {
    logic [5:0] in;
    logic [6:0] exp;
    logic [7:0] src;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b1;
  logic    idle_rr, idle_pr;
  tl_d2h_t p_h0_d2h, p_h1_d2h;
  tl_h2d_t p_d_h2d;
  int      checks = 0;
  int      failures = 0;
  vec_t    vecs [26];

  always #5 clk = ~clk;

  rvlab_tlul_host_arb_if h0_if ();
  rvlab_tlul_host_arb_if h1_if ();
  rvlab_tlul_host_arb_if d_if ();

  rvlab_tlul_host_arb #(.MaxOutstanding(4), .DbgPrio(1'b0)) u_rr (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tl_h0_h2d_i (h0_if.h2d),
    .tl_h0_d2h_o (h0_if.d2h),
    .tl_h1_h2d_i (h1_if.h2d),
    .tl_h1_d2h_o (h1_if.d2h),
    .tl_d_h2d_o  (d_if.h2d),
    .tl_d_d2h_i  (d_if.d2h),
    .idle_o      (idle_rr)
  );

  rvlab_tlul_host_arb #(.MaxOutstanding(4), .DbgPrio(1'b1)) u_prio (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tl_h0_h2d_i (h0_if.h2d),
    .tl_h0_d2h_o (p_h0_d2h),
    .tl_h1_h2d_i (h1_if.h2d),
    .tl_h1_d2h_o (p_h1_d2h),
    .tl_d_h2d_o  (p_d_h2d),
    .tl_d_d2h_i  (d_if.d2h),
    .idle_o      (idle_pr)
  );

  function automatic logic [6:0] obs_rr();
    return {d_if.h2d.a_valid, h0_if.d2h.a_ready, h1_if.d2h.a_ready,
            h0_if.d2h.d_valid, h1_if.d2h.d_valid, d_if.h2d.d_ready, idle_rr};
  endfunction

  function automatic logic [6:0] obs_pr();
    return {p_d_h2d.a_valid, p_h0_d2h.a_ready, p_h1_d2h.a_ready,
            p_h0_d2h.d_valid, p_h1_d2h.d_valid, p_d_h2d.d_ready, idle_pr};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] v);
    h0_if.h2d.a_valid = v[5];
    h1_if.h2d.a_valid = v[4];
    d_if.d2h.a_ready  = v[3];
    d_if.d2h.d_valid  = v[2];
    h0_if.h2d.d_ready = v[1];
    h1_if.h2d.d_ready = v[0];
  endtask

  // One cycle: apply inputs just after the rising edge, sample mid-cycle.
  task automatic step(input logic [5:0] v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    drive(6'b000000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [6:0] o;
    int         hs, gp0, gp1, gr0, gr1;

    // round-robin table: RR on contention, in-order D routing, head-of-line
    // d_ready stall, stray d_valid on empty FIFO, grant lock on a stalled Put
    vecs[0]  = {6'b111011, 7'b1100001, 8'h10};
    vecs[1]  = {6'b011011, 7'b1010010, 8'h21};
    vecs[2]  = {6'b001111, 7'b0001010, 8'h00};
    vecs[3]  = {6'b001111, 7'b0000110, 8'h00};
    vecs[4]  = {6'b001011, 7'b0000001, 8'h00};
    vecs[5]  = {6'b111011, 7'b1100001, 8'h10};
    vecs[6]  = {6'b111011, 7'b1010010, 8'h21};
    vecs[7]  = {6'b111011, 7'b1100010, 8'h10};
    vecs[8]  = {6'b000101, 7'b0001000, 8'h00};
    vecs[9]  = {6'b000101, 7'b0001000, 8'h00};
    vecs[10] = {6'b000101, 7'b0001000, 8'h00};
    vecs[11] = {6'b000110, 7'b0001010, 8'h00};
    vecs[12] = {6'b000110, 7'b0000100, 8'h00};
    vecs[13] = {6'b000111, 7'b0000110, 8'h00};
    vecs[14] = {6'b000111, 7'b0001010, 8'h00};
    vecs[15] = {6'b000111, 7'b0000001, 8'h00};
    vecs[16] = {6'b100011, 7'b1000001, 8'h10};
    vecs[17] = {6'b100011, 7'b1000000, 8'h10};
    vecs[18] = {6'b110011, 7'b1000000, 8'h10};
    vecs[19] = {6'b110011, 7'b1000000, 8'h10};
    vecs[20] = {6'b110011, 7'b1000000, 8'h10};
    vecs[21] = {6'b111011, 7'b1100000, 8'h10};
    vecs[22] = {6'b011011, 7'b1010010, 8'h21};
    vecs[23] = {6'b000111, 7'b0001010, 8'h00};
    vecs[24] = {6'b000111, 7'b0000110, 8'h00};
    vecs[25] = {6'b000011, 7'b0000001, 8'h00};

    h0_if.h2d           = '0;
    h0_if.h2d.a_opcode  = PutFullData;
    h0_if.h2d.a_size    = 2'd2;
    h0_if.h2d.a_source  = 8'h10;
    h0_if.h2d.a_address = 32'h0000_1000;
    h0_if.h2d.a_mask    = 4'hF;
    h0_if.h2d.a_data    = 32'h1111_2222;
    h1_if.h2d           = '0;
    h1_if.h2d.a_opcode  = Get;
    h1_if.h2d.a_size    = 2'd2;
    h1_if.h2d.a_source  = 8'h21;
    h1_if.h2d.a_address = 32'h0000_2000;
    h1_if.h2d.a_mask    = 4'hF;
    d_if.d2h            = '0;
    d_if.d2h.d_opcode   = AccessAckData;
    d_if.d2h.d_source   = 8'h5A;
    d_if.d2h.d_data     = DevData;

    // reset with every input asserted: nothing may leak out
    drive(6'b111111);
    #1 rst_n = 1'b0;
    @(negedge clk);
    o = obs_rr();
    chk("rst_hold_rr", 0, 32'(o[6:1]), 0);
    o = obs_pr();
    chk("rst_hold_pr", 0, 32'(o[6:1]), 0);
    @(posedge clk);
    #1;
    drive(6'b000000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", 0, 32'(obs_rr()), 32'(7'b0000001));

    for (int i = 0; i < 26; i++) begin
      step(vecs[i].in);
      chk("vec_ctl", i, 32'(obs_rr()), 32'(vecs[i].exp));
      chk("vec_src", i, 32'(d_if.h2d.a_source), 32'(vecs[i].src));
      if (vecs[i].exp[3]) chk("vec_h0_data", i, h0_if.d2h.d_data, DevData);
      if (vecs[i].exp[2]) chk("vec_h1_data", i, h1_if.d2h.d_data, DevData);
    end

    // outstanding limit: 6 Gets from host 1, device never answers
    do_reset();
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      step(6'b011011);
      if (h1_if.d2h.a_ready && d_if.h2d.a_valid) hs++;
    end
    chk("max_hs", 0, 32'(hs), 4);
    chk("max_block", 0, 32'(obs_rr()), 32'(7'b0000010));
    step(6'b011111);
    chk("max_pop_cycle", 0, 32'(obs_rr()), 32'(7'b0000110));
    step(6'b011011);
    chk("max_refill", 0, 32'(obs_rr()), 32'(7'b1010010));
    step(6'b011011);
    chk("max_reblock", 0, 32'(obs_rr()), 32'(7'b0000010));

    // both hosts always valid, immediate responses, 10 cycles
    do_reset();
    gp0 = 0; gp1 = 0; gr0 = 0; gr1 = 0;
    for (int i = 0; i < 10; i++) begin
      step(6'b111111);
      if (p_d_h2d.a_valid && p_h0_d2h.a_ready) gp0++;
      if (p_d_h2d.a_valid && p_h1_d2h.a_ready) gp1++;
      if (d_if.h2d.a_valid && h0_if.d2h.a_ready) gr0++;
      if (d_if.h2d.a_valid && h1_if.d2h.a_ready) gr1++;
    end
    chk("prio_h1_grants", 0, 32'(gp1), 10);
    chk("prio_h0_grants", 0, 32'(gp0), 0);
    chk("rr_h0_grants", 0, 32'(gr0), 5);
    chk("rr_h1_grants", 0, 32'(gr1), 5);

    // reset with 3 outstanding and a locked request
    do_reset();
    for (int i = 0; i < 3; i++) step(6'b101011);
    step(6'b100011);
    chk("pre_rst_lock", 0, 32'(obs_rr()), 32'(7'b1000010));
    @(posedge clk);
    #1;
    drive(6'b110111);
    #2 rst_n = 1'b0;
    #1;
    o = obs_rr();
    chk("mid_rst_rr", 0, 32'(o[6:1]), 0);
    o = obs_pr();
    chk("mid_rst_pr", 0, 32'(o[6:1]), 0);
    @(posedge clk);
    #1;
    drive(6'b000000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 0, 32'(obs_rr()), 32'(7'b0000001));
    step(6'b011011);
    chk("post_rst_grant", 0, 32'(obs_rr()), 32'(7'b1010001));
    chk("post_rst_src", 0, 32'(d_if.h2d.a_source), 32'h21);
    step(6'b000111);
    chk("post_rst_resp", 0, 32'(obs_rr()), 32'(7'b0000110));
    step(6'b000000);
    chk("post_rst_done", 0, 32'(obs_rr()), 32'(7'b0000001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvlab_tlul_host_arb.md
RVLAB_TLUL_HOST_ARB -- requirements
Module: rvlab_tlul_host_arb

Interface
REQ-001 Parameter MaxOutstanding, default 4, maximum accepted A-channel requests not yet answered on D channel (range 1..8).
REQ-002 Parameter DbgPrio, default 0; 0 selects round-robin, 1 gives host 1 (debug SBA) fixed priority.
REQ-003 clk_i  input  1  single clock for all logic.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 tl_h0_h2d_i  input  tlul_pkg::tl_h2d_t  host 0 request (core data port).
REQ-006 tl_h0_d2h_o  output  tlul_pkg::tl_d2h_t  host 0 response.
REQ-007 tl_h1_h2d_i  input  tlul_pkg::tl_h2d_t  host 1 request (debug SBA port).
REQ-008 tl_h1_d2h_o  output  tlul_pkg::tl_d2h_t  host 1 response.
REQ-009 tl_d_h2d_o  output  tlul_pkg::tl_h2d_t  shared device-side request.
REQ-010 tl_d_d2h_i  input  tlul_pkg::tl_d2h_t  shared device-side response.
REQ-011 idle_o  output  1  high when no request is granted-and-pending and outstanding count is 0.

Function
REQ-012 Arbiter FSM states: IDLE (no grant held), LOCKED (grant held, a_valid high, a_ready not yet seen).
REQ-013 In IDLE, if outstanding count < MaxOutstanding and any a_valid high, grant selected host combinationally same cycle; forward its A fields to tl_d_h2d_o.
REQ-014 Round-robin: on contention grant the host not granted last; last-granted pointer resets to host 1, so first contention after reset grants host 0.
REQ-015 DbgPrio=1: host 1 wins every contention; host 0 served only when host 1 a_valid low.
REQ-016 Granted host a_ready = tl_d_d2h_i.a_ready; non-granted host a_ready = 0.
REQ-017 If granted a_valid high and device a_ready low, move to LOCKED; grant frozen until handshake, regardless of other host.
REQ-018 On A handshake (d-side a_valid && a_ready), push granted host index into ID FIFO, update last-granted pointer, return to IDLE; a new grant can issue next cycle.
REQ-019 When outstanding count == MaxOutstanding, tl_d_h2d_o.a_valid = 0 and both hosts see a_ready = 0; a D pop in the same cycle does not unblock that cycle.
REQ-020 D channel routed to host at FIFO head: that host d_valid = device d_valid, all D fields forwarded; other host d_valid = 0.
REQ-021 Device d_ready = d_ready of head host; 0 when FIFO empty.
REQ-022 FIFO pop on d-side d_valid && d_ready; simultaneous push and pop keep count unchanged and preserve order.
REQ-023 d_valid from device while FIFO empty is ignored (d_ready=0) and sets no state; bench flags it as device protocol error.
REQ-024 A-field passthrough is zero-latency; arbitration adds no pipeline register on A or D data.
REQ-025 Device responses are in order; arbiter does not rewrite a_source/d_source.

Reset
REQ-026 On rst_ni low: FSM IDLE, FIFO empty, count 0, last-granted = host 1.
REQ-027 During and after reset until first grant: all a_valid/d_valid outputs 0, all a_ready/d_ready outputs 0, idle_o = 1 (after deassertion).
REQ-028 Reset mid-transaction drops all pending and outstanding requests without issuing responses.

Structure
REQ-029 Host-index type, NumHosts = 2, and FSM state enum reside in package rvlab_tlul_arb_pkg.
REQ-030 ID FIFO is sub-module rvlab_arb_id_fifo (depth MaxOutstanding, width 1, count output, flow-through disabled).
REQ-031 TL-UL struct types come only from tlul_pkg.

Verification
REQ-032 Both hosts assert Get at cycle 0 after reset, device a_ready=1 -> host 0 handshakes cycle 0, host 1 cycle 1; responses return to h0 then h1.
REQ-033 Host 0 Put held with device a_ready=0 for 5 cycles while host 1 raises a_valid at cycle 2 -> grant stays host 0 until handshake at cycle 5, host 1 granted cycle 6.
REQ-034 MaxOutstanding=4, device never responds, host 1 issues 6 Gets -> exactly 4 handshakes, then a_ready=0; one D response frees one slot, fifth accepted next cycle.
REQ-035 DbgPrio=1, both hosts continuously valid for 10 cycles with immediate responses -> host 1 receives all 10 grants, host 0 none.
REQ-036 Interleaved h0,h1,h0 requests with head host holding d_ready=0 for 3 cycles -> no D beat to other host, order h0,h1,h0 preserved.
REQ-037 rst_ni asserted with 3 outstanding and one LOCKED request -> all valid/ready outputs 0 immediately, idle_o=1 after release, next request granted cleanly.
